// File: rtl/fifo_prog.sv
// Single-clock synchronous FIFO with programmable almost-full/almost-empty
// thresholds, synchronous flush, sticky overflow/underflow flags and both read modes.
module fifo_prog #(
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 10,
    parameter int SHOWAHEAD = 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              flush_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    input  logic [AWIDTH:0]   af_thresh_i,
    input  logic [AWIDTH:0]   ae_thresh_i,
    input  logic              clr_err_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int              DEPTH    = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE_CNT  = {{AWIDTH{1'b0}}, 1'b1};

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH-1:0] rd_ptr_nxt;
    logic [AWIDTH:0]   usedw;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              unf_set;

    assign empty_o        = (usedw == '0);
    assign full_o         = (usedw == FULL_CNT);
    assign usedw_o        = usedw;
    assign almost_full_o  = (usedw >= af_thresh_i);
    assign almost_empty_o = (usedw <= ae_thresh_i);

    // Flush outranks everything: it blocks both accepts and both error sets.
    assign wr_acc     = wrreq_i && !full_o  && !flush_i;
    assign rd_acc     = rdreq_i && !empty_o && !flush_i;
    assign ovf_set    = wrreq_i && full_o   && !flush_i;
    assign unf_set    = rdreq_i && empty_o  && !flush_i;
    assign rd_ptr_nxt = rd_ptr + {{(AWIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + {{(AWIDTH-1){1'b0}}, 1'b1};
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({wr_acc, rd_acc})
                2'b10:   usedw <= usedw + ONE_CNT;
                2'b01:   usedw <= usedw - ONE_CNT;
                default: usedw <= usedw;
            endcase
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // q_o is the head register: a write that becomes the head is
            // bypassed straight in, otherwise a read prefetches the next word.
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    q_o <= '0;
                end else if (wr_acc && (empty_o || (usedw == ONE_CNT && rd_acc))) begin
                    q_o <= data_i;
                end else if (rd_acc && usedw > ONE_CNT) begin
                    q_o <= mem[rd_ptr_nxt];
                end
            end
        end else begin : g_normal
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    q_o <= '0;
                end else if (rd_acc) begin
                    q_o <= mem[rd_ptr];
                end
            end
        end
    endgenerate

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clr_err_i) begin
                overflow_o <= 1'b0;
            end
            if (unf_set) begin
                underflow_o <= 1'b1;
            end else if (clr_err_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: showahead and normal-mode instances share one stimulus
// stream and are compared every cycle against a queue-based model.
module tb_fifo_prog;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk_i    = 1'b0;
    logic arst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          flush_i     = 1'b0;
    logic [DW-1:0] data_i      = '0;
    logic          wrreq_i     = 1'b0;
    logic          rdreq_i     = 1'b0;
    logic [AW:0]   af_thresh_i = 4'd6;
    logic [AW:0]   ae_thresh_i = 4'd1;
    logic          clr_err_i   = 1'b0;

    logic [DW-1:0] q_sa, q_nm;
    logic          empty_sa, full_sa, af_sa, ae_sa, ovf_sa, unf_sa;
    logic          empty_nm, full_nm, af_nm, ae_nm, ovf_nm, unf_nm;
    logic [AW:0]   usedw_sa, usedw_nm;

    fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1)) u_dut_sa (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .flush_i(flush_i), .data_i(data_i),
        .wrreq_i(wrreq_i), .rdreq_i(rdreq_i), .af_thresh_i(af_thresh_i),
        .ae_thresh_i(ae_thresh_i), .clr_err_i(clr_err_i), .q_o(q_sa),
        .empty_o(empty_sa), .full_o(full_sa), .usedw_o(usedw_sa),
        .almost_full_o(af_sa), .almost_empty_o(ae_sa),
        .overflow_o(ovf_sa), .underflow_o(unf_sa)
    );

    fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(0)) u_dut_nm (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .flush_i(flush_i), .data_i(data_i),
        .wrreq_i(wrreq_i), .rdreq_i(rdreq_i), .af_thresh_i(af_thresh_i),
        .ae_thresh_i(ae_thresh_i), .clr_err_i(clr_err_i), .q_o(q_nm),
        .empty_o(empty_nm), .full_o(full_nm), .usedw_o(usedw_nm),
        .almost_full_o(af_nm), .almost_empty_o(ae_nm),
        .overflow_o(ovf_nm), .underflow_o(unf_nm)
    );

    // ---------------- scoreboard / model ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;
    logic [DW-1:0] m_q_sa  = '0;
    logic [DW-1:0] m_q_nm  = '0;
    logic          m_full  = 1'b0;
    logic          m_empty = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_q_sa = '0;
            m_q_nm = '0;
        end else if (flush_i) begin
            exp_q.delete();
            if (clr_err_i) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            m_full  = (exp_q.size() == DEPTH);
            m_empty = (exp_q.size() == 0);
            if (wrreq_i && m_full) m_ovf = 1'b1;
            else if (clr_err_i)    m_ovf = 1'b0;
            if (rdreq_i && m_empty) m_unf = 1'b1;
            else if (clr_err_i)     m_unf = 1'b0;
            if (rdreq_i && !m_empty) m_q_nm = exp_q.pop_front();
            if (wrreq_i && !m_full)  exp_q.push_back(data_i);
            if (exp_q.size() > 0)    m_q_sa = exp_q[0];
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk_i) begin
        int sz;
        sz = exp_q.size();
        check("usedw_sa", 32'(usedw_sa), 32'(sz));
        check("usedw_nm", 32'(usedw_nm), 32'(sz));
        check("empty_sa", 32'(empty_sa), 32'(sz == 0));
        check("empty_nm", 32'(empty_nm), 32'(sz == 0));
        check("full_sa",  32'(full_sa),  32'(sz == DEPTH));
        check("full_nm",  32'(full_nm),  32'(sz == DEPTH));
        check("af_sa",    32'(af_sa),    32'(sz >= int'(af_thresh_i)));
        check("af_nm",    32'(af_nm),    32'(sz >= int'(af_thresh_i)));
        check("ae_sa",    32'(ae_sa),    32'(sz <= int'(ae_thresh_i)));
        check("ae_nm",    32'(ae_nm),    32'(sz <= int'(ae_thresh_i)));
        check("ovf_sa",   32'(ovf_sa),   32'(m_ovf));
        check("ovf_nm",   32'(ovf_nm),   32'(m_ovf));
        check("unf_sa",   32'(unf_sa),   32'(m_unf));
        check("unf_nm",   32'(unf_nm),   32'(m_unf));
        check("q_sa",     32'(q_sa),     32'(m_q_sa));
        check("q_nm",     32'(q_nm),     32'(m_q_nm));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic fl, input logic clr);
        wrreq_i   = wr;
        rdreq_i   = rd;
        data_i    = d;
        flush_i   = fl;
        clr_err_i = clr;
        @(posedge clk_i);
        #1;
        wrreq_i   = 1'b0;
        rdreq_i   = 1'b0;
        flush_i   = 1'b0;
        clr_err_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, 32'({empty_sa, empty_nm}), 32'd3);
        check({tag, "_full"},  32'({full_sa, full_nm}),   32'd0);
        check({tag, "_usedw"}, 32'({usedw_sa, usedw_nm}), 32'd0);
        check({tag, "_ae"},    32'({ae_sa, ae_nm}),       32'd3);
        check({tag, "_af"},    32'({af_sa, af_nm}),       32'd0);
        check({tag, "_err"},   32'({ovf_sa, unf_sa, ovf_nm, unf_nm}), 32'd0);
        check({tag, "_q"},     32'({q_sa, q_nm}),         32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_vals("reset");
        #3 arst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill with threshold stepping.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
            check("fill_usedw", 32'(usedw_sa), 32'(i + 1));
            check("fill_ae",    32'(ae_sa),    32'((i + 1) <= 1));
            check("fill_af",    32'(af_nm),    32'((i + 1) >= 6));
        end
        check("fill_full", 32'({full_sa, full_nm}), 32'd3);
        check("fill_head", 32'(q_sa), 32'h10);

        // Drain in order.
        for (int i = 0; i < 8; i++) begin
            check("drain_q_sa", 32'(q_sa), 32'(8'h10 + 8'(i)));
            cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            check("drain_q_nm", 32'(q_nm), 32'(8'h10 + 8'(i)));
        end
        check("drain_empty", 32'({empty_sa, empty_nm}), 32'd3);
        check("drain_err",   32'({ovf_sa, unf_sa}), 32'd0);

        // Showahead first-word latency.
        cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        check("sa_q",     32'(q_sa), 32'hA5);
        check("sa_empty", 32'(empty_sa), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("nm_q_a5", 32'(q_nm), 32'hA5);

        // Full with read+write, then underflow, set-over-clear, clear.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        check("full_rw_usedw", 32'(usedw_nm), 32'd7);
        check("full_rw_ovf",   32'({ovf_sa, ovf_nm}), 32'd3);
        check("full_rw_q_nm",  32'(q_nm), 32'h20);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("nm_q_last", 32'(q_nm), 32'h27);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("unf_set",   32'({unf_sa, unf_nm}), 32'd3);
        check("unf_usedw", 32'(usedw_sa), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        check("set_over_clr", 32'(unf_sa), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_err", 32'({ovf_sa, unf_sa, ovf_nm, unf_nm}), 32'd0);

        // Threshold reprogramming takes effect combinationally.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0, 1'b0);
        check("af_at4", 32'(af_sa), 32'd0);
        af_thresh_i = 4'd3;
        #1;
        check("af_reprog", 32'({af_sa, af_nm}), 32'd3);
        af_thresh_i = 4'd6;
        #1;
        check("af_restore", 32'(af_sa), 32'd0);

        // Steady state: 20 simultaneous read+write cycles at usedw 4.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
            check("steady_usedw", 32'(usedw_sa), 32'd4);
            check("steady_q_nm", 32'(q_nm), (i < 4) ? 32'(8'h30 + 8'(i)) : 32'(8'h40 + 8'(i - 4)));
        end

        // Flush at usedw 5 with a write, then flush at full with both requests.
        cyc(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        check("pre_flush_usedw", 32'(usedw_nm), 32'd5);
        cyc(1'b1, 1'b0, 8'h66, 1'b1, 1'b0);
        check("flush_usedw", 32'({usedw_sa, usedw_nm}), 32'd0);
        check("flush_empty", 32'({empty_sa, empty_nm}), 32'd3);
        check("flush_ovf",   32'(ovf_sa), 32'd0);
        check("flush_q_sa",  32'(q_sa), 32'h50);
        check("flush_q_nm",  32'(q_nm), 32'h4F);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        check("flush_full_err", 32'({ovf_sa, unf_sa, ovf_nm, unf_nm}), 32'd0);
        check("flush_full_usedw", 32'(usedw_sa), 32'd0);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h80 + 8'(i), 1'b0, 1'b0);
        wrreq_i = 1'b1;
        data_i  = 8'h88;
        #2 arst_n_i = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(posedge clk_i);
        #1;
        wrreq_i = 1'b0;
        #3 arst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        check("post_rst_q_sa", 32'(q_sa), 32'h99);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("post_rst_q_nm", 32'(q_nm), 32'h99);
        repeat (2) @(posedge clk_i);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
- Second-generation single-clock synchronous FIFO for the datapath buffering layer.
- Extends the earlier fixed-threshold FIFO with:
  - runtime-programmable almost-full/almost-empty thresholds,
  - a synchronous flush,
  - sticky overflow/underflow error flags,
  - both read modes (showahead and normal) with identical latency rules.
- Storage is an internal inferred RAM of 2**AWIDTH words.
- Sits between producer and consumer blocks wherever back-pressure status and error visibility are required.

Parameters:
- DWIDTH, 64, data word width in bits
- AWIDTH, 10, address width; depth = 2**AWIDTH words
- SHOWAHEAD, 1, 1 = head word presented on q_o without a read; 0 = q_o updated one cycle after an accepted read

Ports:
- clk_i  in  1  clock; all logic on rising edge
- arst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush, highest priority
- data_i  in  DWIDTH  write data
- wrreq_i  in  1  write request
- rdreq_i  in  1  read request
- af_thresh_i  in  AWIDTH+1  almost-full threshold (quasi-static)
- ae_thresh_i  in  AWIDTH+1  almost-empty threshold (quasi-static)
- clr_err_i  in  1  clears sticky error flags
- q_o  out  DWIDTH  read data
- empty_o  out  1  no readable word
- full_o  out  1  usedw_o == 2**AWIDTH
- usedw_o  out  AWIDTH+1  words stored
- almost_full_o  out  1  usedw_o >= af_thresh_i
- almost_empty_o  out  1  usedw_o <= ae_thresh_i
- overflow_o  out  1  sticky: write attempted while full
- underflow_o  out  1  sticky: read attempted while empty

Behaviour:
- Reset (arst_n_i low, asynchronous, any cycle):
  - pointers and usedw cleared to 0; contents discarded;
  - empty_o=1, full_o=0, usedw_o=0, almost_empty_o=(0<=ae_thresh_i)=1, almost_full_o=(af_thresh_i==0);
  - overflow_o=0, underflow_o=0, q_o=0.
  - Deassertion is used synchronously by the integrator; no requests arrive in the release cycle.
- Accept rules:
  - Write accepted iff wrreq_i && !full_o && !flush_i.
  - Read accepted iff rdreq_i && !empty_o && !flush_i.
  - Refused requests have no effect on storage, pointers or usedw.
- usedw:
  - Registered; next = usedw + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves it unchanged.
  - Range 0..2**AWIDTH inclusive.
- Status outputs:
  - empty_o = (usedw==0); full_o = (usedw==2**AWIDTH).
  - Both take effect the cycle after the accepting edge.
  - At full with rdreq_i && wrreq_i: read accepted, write refused.
  - At empty with both: write accepted, read refused.
- Pointers: AWIDTH-bit rd/wr pointers, incremented on accept, wrapping 2**AWIDTH-1 -> 0 with no gap.
- SHOWAHEAD=1:
  - Whenever empty_o=0, q_o holds the oldest stored word.
  - A write into an empty FIFO at edge N gives empty_o=0 and q_o=that word after edge N (the next cycle). A first-word bypass/prefetch register is required.
  - After an accepted read at edge N, q_o shows the next word after edge N if usedw>1.
  - q_o holds its last value while empty.
- SHOWAHEAD=0:
  - An accepted read at edge N loads q_o with the head word after edge N (one-cycle latency).
  - q_o otherwise holds its value.
- Almost flags: combinational compares of registered usedw against the thresholds, inclusive as in Ports; full AWIDTH+1-bit unsigned compare.
- Error flags:
  - overflow_o sets on wrreq_i && full_o && !flush_i.
  - underflow_o sets on rdreq_i && empty_o && !flush_i.
  - Both are sticky until a clr_err_i edge; set wins over clear in the same cycle.
- flush_i:
  - After the edge: pointers=0, usedw=0, empty_o=1.
  - Same-cycle wrreq/rdreq are ignored and set no error flags.
  - Error flags and q_o are unchanged.

Test Plan (DWIDTH=8, AWIDTH=3, depth 8, af=6, ae=1, both modes unless noted):
- Fill then drain: write 0x10..0x17 -> full_o=1 and usedw_o=8 after the 8th edge. Read 8 -> data 0x10..0x17 in order, empty_o=1, usedw_o=0, no error flags.
- Showahead latency (SHOWAHEAD=1): single write 0xA5 into empty at edge N -> after N: empty_o=0, q_o=0xA5, rdreq_i not asserted.
- Boundaries and errors: at full, wrreq_i+rdreq_i -> read accepted, usedw_o 8->7, overflow_o=1. At empty, rdreq_i -> underflow_o=1, usedw_o=0. clr_err_i -> both flags 0 next cycle.
- Thresholds: usedw_o stepped 0..8 -> almost_empty_o=1 at 0..1, almost_full_o=1 at 6..8. Reprogramming af to 3 at usedw_o=4 -> almost_full_o=1 immediately.
- Wrap and steady state: 20 cycles of simultaneous read+write at usedw_o=4 -> usedw_o constant at 4, pointers wrap at least twice, output sequence exactly matches the input sequence.
- Flush and reset mid-traffic:
  - flush_i with usedw_o=5 plus wrreq_i -> usedw_o=0, empty_o=1, no overflow.
  - arst_n_i low mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.
